// File: rtl/dds_wave_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : dds_wave_gen_if
//  Description : Signal bundle between the DDS waveform generator and its
//                environment (keys, waveform select, external sine ROM and
//                the sample output towards the DAC / scope path).
//                  wave_sel   [1:0]      00 sine, 01 square, 10 tri, 11 saw
//                  freq_add / freq_dec   raw, asynchronous push buttons
//                  rom_addr   [ADDR_W]   registered address to sine ROM
//                  rom_data   [DATA_W]   ROM data, one cycle after rom_addr
//                  freq_word  [PHASE_W]  current frequency word
//                  wave_out   [DATA_W]   registered output sample
//                  wave_valid            pipeline filled since last reset
//                  amp_shift  [2:0]      only with DDS_AMP_SCALE_EN defined
//                Modport "slave" is the generator, "master" its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface dds_wave_gen_if #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8
);
    logic [1:0]         wave_sel;
    logic               freq_add;
    logic               freq_dec;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_data;
    logic [PHASE_W-1:0] freq_word;
    logic [DATA_W-1:0]  wave_out;
    logic               wave_valid;

`ifdef DDS_AMP_SCALE_EN
    logic [2:0]         amp_shift;

    modport master (
        output wave_sel, freq_add, freq_dec, rom_data, amp_shift,
        input  rom_addr, freq_word, wave_out, wave_valid
    );

    modport slave (
        input  wave_sel, freq_add, freq_dec, rom_data, amp_shift,
        output rom_addr, freq_word, wave_out, wave_valid
    );
`else
    modport master (
        output wave_sel, freq_add, freq_dec, rom_data,
        input  rom_addr, freq_word, wave_out, wave_valid
    );

    modport slave (
        input  wave_sel, freq_add, freq_dec, rom_data,
        output rom_addr, freq_word, wave_out, wave_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dds_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dds_wave_gen
//  Description : Parametrised DDS waveform generator.
//                Two push buttons (freq_add / freq_dec) are synchronised,
//                debounced and edge-detected; each accepted press steps a
//                saturating frequency word.  A phase accumulator advances by
//                the frequency word every cycle and its top ADDR_W bits
//                address an external synchronous sine ROM.  Square, triangle
//                and sawtooth are derived from the same address so every
//                mode has the same 3-cycle latency from the phase register
//                to wave_out.
//  Ports       : sys_clk   system clock, rising edge
//                reset     synchronous, active-high
//                bus       dds_wave_gen_if.slave (select, keys, ROM, output)
//  Options     : DDS_AMP_SCALE_EN - when defined, adds bus.amp_shift[2:0];
//                the output sample is shifted right (zero fill) by it in
//                the final stage, latency unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
module dds_wave_gen #(
    parameter int                 PHASE_W     = 24,
    parameter int                 ADDR_W      = 12,   // must be >= DATA_W+1
    parameter int                 DATA_W      = 8,
    parameter logic [PHASE_W-1:0] FWORD_RESET = 24'h001000,
    parameter logic [PHASE_W-1:0] FSTEP       = 24'h000400,
    parameter logic [PHASE_W-1:0] FWORD_MIN   = 24'h000400,
    parameter logic [PHASE_W-1:0] FWORD_MAX   = 24'h400000,
    parameter int                 DEB_CYCLES  = 500000
) (
    input  wire logic     sys_clk,
    input  wire logic     reset,
    dds_wave_gen_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Debounce counter only has to reach DEB_CYCLES-1.
    localparam int c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);
    // Only the top DATA_W+1 address bits are needed by the derived shapes.
    localparam int c_tri_w = DATA_W + 1;

    // ------------------------------------------------------------------
    // Key conditioning: 2-FF synchroniser, debounce counter, rising-edge
    // detect.  Index 0 = freq_add, index 1 = freq_dec.
    // ------------------------------------------------------------------
    logic [1:0] w_keys_raw;
    logic [1:0] w_press;

    assign w_keys_raw = {bus.freq_dec, bus.freq_add};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic               r_meta;
        logic               r_sync;
        logic               r_level;
        logic               r_level_d;
        logic [c_cnt_w-1:0] r_cnt;

        always_ff @(posedge sys_clk) begin
            if (reset) begin
                r_meta    <= 1'b0;
                r_sync    <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_meta    <= w_keys_raw[gi];
                r_sync    <= r_meta;
                r_level_d <= r_level;
                // The counter measures how long the synchronised input has
                // disagreed with the accepted level; any agreeing sample
                // restarts it, so only an uninterrupted run flips the level.
                if (r_sync == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end

        // One-cycle pulse on the accepted 0->1 transition; a held key
        // keeps r_level high and therefore never re-triggers.
        assign w_press[gi] = r_level & ~r_level_d;
    end

    // ------------------------------------------------------------------
    // Saturating frequency word
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] r_freq_word;
    logic [PHASE_W:0]   w_add_sum;
    logic [PHASE_W:0]   w_dec_floor;
    logic [PHASE_W-1:0] w_add_next;
    logic [PHASE_W-1:0] w_dec_next;

    // Sum is one bit wider so that a step past 2^PHASE_W cannot wrap
    // below FWORD_MAX and escape the clamp.
    assign w_add_sum  = {1'b0, r_freq_word} + {1'b0, FSTEP};
    assign w_add_next = (w_add_sum > {1'b0, FWORD_MAX}) ? FWORD_MAX
                                                        : w_add_sum[PHASE_W-1:0];

    // Comparing against MIN+STEP instead of subtracting first avoids any
    // underflow when the word is already below one step.
    assign w_dec_floor = {1'b0, FWORD_MIN} + {1'b0, FSTEP};
    assign w_dec_next  = ({1'b0, r_freq_word} < w_dec_floor) ? FWORD_MIN
                                                             : (r_freq_word - FSTEP);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_freq_word <= FWORD_RESET;
        end else begin
            case (w_press)
                2'b01:   r_freq_word <= w_add_next;
                2'b10:   r_freq_word <= w_dec_next;
                default: r_freq_word <= r_freq_word;   // none or both
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Phase accumulator (wraps modulo 2^PHASE_W)
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] r_phase;
    logic [ADDR_W-1:0]  w_addr;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + r_freq_word;
        end
    end

    assign w_addr = r_phase[PHASE_W-1 -: ADDR_W];

    // ------------------------------------------------------------------
    // Address / select pipeline.  Stage 1 launches the ROM address and
    // captures the matching select; stage 2 waits for the ROM; stage 3
    // forms the sample.  Carrying wave_sel alongside the address is what
    // makes a mode change land on exactly the right sample.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [c_tri_w-1:0] r_addr_d1;
    logic [c_tri_w-1:0] r_addr_d2;
    logic [1:0]         r_sel_d1;
    logic [1:0]         r_sel_d2;
    logic [2:0]         r_fill;
    logic [DATA_W-1:0]  r_wave_out;
    logic [DATA_W-1:0]  w_sample;
    logic [DATA_W-1:0]  w_scaled;

`ifdef DDS_AMP_SCALE_EN
    logic [2:0]         r_shift_d1;
    logic [2:0]         r_shift_d2;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_shift_d1 <= 3'd0;
            r_shift_d2 <= 3'd0;
        end else begin
            r_shift_d1 <= bus.amp_shift;
            r_shift_d2 <= r_shift_d1;
        end
    end

    assign w_scaled = w_sample >> r_shift_d2;
`else
    assign w_scaled = w_sample;
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_addr_d1  <= '0;
            r_addr_d2  <= '0;
            r_sel_d1   <= 2'b00;
            r_sel_d2   <= 2'b00;
        end else begin
            r_rom_addr <= w_addr;
            r_addr_d1  <= w_addr[ADDR_W-1 -: c_tri_w];
            r_sel_d1   <= bus.wave_sel;
            r_addr_d2  <= r_addr_d1;
            r_sel_d2   <= r_sel_d1;
        end
    end

    // Waveform shaping from the twice-delayed address (aligned with ROM data).
    always_comb begin
        w_sample = '0;
        case (r_sel_d2)
            2'b00: w_sample = bus.rom_data;
            2'b01: w_sample = r_addr_d2[DATA_W] ? '0 : '1;
            // Second half of the period mirrors the first, giving a
            // symmetric ramp up then down.
            2'b10: w_sample = r_addr_d2[DATA_W] ? ~r_addr_d2[DATA_W-1:0]
                                                :  r_addr_d2[DATA_W-1:0];
            default: w_sample = r_addr_d2[DATA_W:1];
        endcase
    end

    // r_fill counts the first three edges after reset.  The output register
    // is loaded with real data on the same edge that r_fill[2] sets, which
    // is the edge the first phase sample reaches the end of the pipeline;
    // before that it is held at zero.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_fill     <= 3'b000;
            r_wave_out <= '0;
        end else begin
            r_fill     <= {r_fill[1:0], 1'b1};
            r_wave_out <= r_fill[1] ? w_scaled : '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rom_addr   = r_rom_addr;
    assign bus.freq_word  = r_freq_word;
    assign bus.wave_out   = r_wave_out;
    assign bus.wave_valid = r_fill[2];

endmodule
`default_nettype wire

// File: tb/tb_dds_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_wave_gen
//  Description : Self-checking bench for dds_wave_gen (DEB_CYCLES=4).
//                Stimulus pushes the expected sample for every phase value
//                into a queue; an independent monitor pops and compares
//                whenever wave_valid is high.  Key handling is checked
//                directly on freq_word.  Includes a sine ROM model that
//                returns addr[11:4] one cycle after the address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dds_wave_gen;
    localparam int PHASE_W = 24;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dds_wave_gen_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dds_wave_gen #(
        .PHASE_W    (PHASE_W),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEB_CYCLES (4)
    ) dut (
        .sys_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    // External synchronous sine ROM stand-in: data = addr[11:4].
    always @(posedge clk) bus.rom_data <= bus.rom_addr[11:4];

    int           checks   = 0;
    int           failures = 0;
    logic [7:0]   exp_q[$];
    bit           track    = 1'b0;
    logic [23:0]  phase_m  = '0;
    logic [23:0]  fw_m     = 24'h001000;
    int           amp_sh   = 0;
    logic [7:0]   peak     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Expected sample for a given phase, written from the waveform shapes.
    function automatic logic [7:0] model(input logic [23:0] ph, input logic [1:0] sel, input int sh);
        int a;
        int v;
        a = int'(ph[23:12]);
        case (sel)
            2'd0:    v = a / 16;                       // ROM model contents
            2'd1:    v = (a < 2048) ? 255 : 0;
            2'd2:    v = (a < 2048) ? a / 8 : 255 - (a - 2048) / 8;
            default: v = a / 16;
        endcase
        v = v >> sh;
        return v[7:0];
    endfunction

    // Monitor: compares every valid sample against the queue head.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (track) begin
                if (bus.wave_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL wave_q_empty actual=valid_sample expected=no_sample");
                    end else begin
                        e = exp_q.pop_front();
                        check("wave_out", {24'h0, bus.wave_out}, {24'h0, e});
                        if (bus.wave_out > peak) peak = bus.wave_out;
                    end
                end else begin
                    check("wave_out_idle", {24'h0, bus.wave_out}, 32'h0);
                end
            end
        end
    end

    // Called at a negedge with inputs for the current cycle already set.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [11:0] a_prev;
            if (track) exp_q.push_back(model(phase_m, bus.wave_sel, amp_sh));
            a_prev = phase_m[23:12];
            @(negedge clk);
            phase_m = phase_m + fw_m;
            if (track) check("rom_addr", {20'h0, bus.rom_addr}, {20'h0, a_prev});
        end
    endtask

    task automatic do_reset(input int n);
        track = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        repeat (n) @(negedge clk);
        check("rst_wave_out",  {24'h0, bus.wave_out}, 32'h0);
        check("rst_freq_word", {8'h0, bus.freq_word}, 32'h001000);
        check("rst_rom_addr",  {20'h0, bus.rom_addr}, 32'h0);
        check("rst_valid",     {31'h0, bus.wave_valid}, 32'h0);
        rst     = 1'b0;
        phase_m = '0;
        fw_m    = 24'h001000;
        track   = 1'b1;
    endtask

    task automatic press(input bit add, input bit dec, input int hi, input int lo);
        bus.freq_add = add;
        bus.freq_dec = dec;
        repeat (hi) @(negedge clk);
        bus.freq_add = 1'b0;
        bus.freq_dec = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        bus.wave_sel = 2'b11;
        bus.freq_add = 1'b0;
        bus.freq_dec = 1'b0;
`ifdef DDS_AMP_SCALE_EN
        bus.amp_shift = 3'd0;
`endif
        // Reset for 3 cycles, then watch wave_valid rise on edge 3.
        do_reset(3);
        run_cycles(1);
        check("valid_edge1", {31'h0, bus.wave_valid}, 32'h0);
        run_cycles(1);
        check("valid_edge2", {31'h0, bus.wave_valid}, 32'h0);
        run_cycles(1);
        check("valid_edge3", {31'h0, bus.wave_valid}, 32'h1);

        // Sawtooth, square, triangle over more than a full period each.
        run_cycles(4300);
        bus.wave_sel = 2'b01;
        run_cycles(4200);
        bus.wave_sel = 2'b10;
        run_cycles(4200);
        // Sine through the ROM model.
        bus.wave_sel = 2'b00;
        run_cycles(300);

        // Sawtooth peak, with amplitude scaling when present.
        bus.wave_sel = 2'b11;
`ifdef DDS_AMP_SCALE_EN
        amp_sh        = 2;
        bus.amp_shift = 3'd2;
`endif
        run_cycles(4);
        peak = '0;
        run_cycles(4200);
`ifdef DDS_AMP_SCALE_EN
        check("saw_peak_scaled", {24'h0, peak}, 32'h3f);
`else
        check("saw_peak", {24'h0, peak}, 32'hff);
`endif

        // Key handling: freq_word changes at an unpredicted cycle, so the
        // sample stream is not tracked here.
        track = 1'b0;
        exp_q.delete();
        check("fw_before_keys", {8'h0, bus.freq_word}, 32'h001000);
        press(1'b1, 1'b0, 10, 10);
        check("fw_add_once", {8'h0, bus.freq_word}, 32'h001400);
        press(1'b1, 1'b0, 2, 10);
        check("fw_glitch", {8'h0, bus.freq_word}, 32'h001400);
        press(1'b1, 1'b1, 10, 10);
        check("fw_both", {8'h0, bus.freq_word}, 32'h001400);
        press(1'b0, 1'b1, 5, 5);
        check("fw_dec1", {8'h0, bus.freq_word}, 32'h001000);
        repeat (3) press(1'b0, 1'b1, 5, 5);
        check("fw_dec_min", {8'h0, bus.freq_word}, 32'h000400);
        press(1'b0, 1'b1, 5, 5);
        check("fw_dec_sat", {8'h0, bus.freq_word}, 32'h000400);
        repeat (4095) press(1'b1, 1'b0, 5, 5);
        check("fw_add_max", {8'h0, bus.freq_word}, 32'h400000);
        press(1'b1, 1'b0, 5, 5);
        check("fw_add_sat", {8'h0, bus.freq_word}, 32'h400000);
        press(1'b0, 1'b1, 5, 5);
        check("fw_dec_from_max", {8'h0, bus.freq_word}, 32'h3ffc00);

        // Mid-operation reset: a single edge must restore everything.
        do_reset(1);
        run_cycles(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
